// File: rtl/stream_reduce_serial.sv
// Frame reducer: collects a burst of DATA_W-bit symbols, reduces it with SUM/MAX/MIN/POP
// and returns the RES_W-bit result serially, LSB first, under out_valid.
module stream_reduce_serial #(
    parameter int DATA_W  = 4,
    parameter int MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    output logic              result
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int RES_W = DATA_W + CNT_W;
    localparam int BIT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(RES_W - 1);

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;
    localparam logic [1:0] MODE_POP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_OUT     = 2'b10
    } state_t;

    // POP must never wrap: the worst-case bit count has to fit the result width.
    if (MAX_LEN * DATA_W >= (1 << RES_W)) begin : g_pop_range_chk
        $error("stream_reduce_serial: MAX_LEN*DATA_W does not fit in RES_W bits");
    end

    function automatic logic [RES_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [RES_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{(RES_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   count_q;
    logic [RES_W-1:0]   acc_q;
    logic [RES_W-1:0]   shift_q;
    logic [BIT_W-1:0]   bit_q;
    logic               out_valid_q;
    logic               result_q;

    logic [RES_W-1:0]   sym_ext_s;
    logic [RES_W-1:0]   sym_pop_s;
    logic [RES_W-1:0]   first_d;
    logic [RES_W-1:0]   fold_d;

    // Seed value for a new frame and the folded accumulator for follow-on symbols.
    always_comb begin
        sym_ext_s = {{CNT_W{1'b0}}, data};
        sym_pop_s = popcount(data);
        first_d   = sym_ext_s;
        fold_d    = acc_q;
        if (mode == MODE_POP) begin
            first_d = sym_pop_s;
        end else begin
            first_d = sym_ext_s;
        end
        case (mode_q)
            MODE_SUM: fold_d = acc_q + sym_ext_s;
            MODE_MAX: begin
                if (sym_ext_s > acc_q) begin
                    fold_d = sym_ext_s;
                end else begin
                    fold_d = acc_q;
                end
            end
            MODE_MIN: begin
                if (sym_ext_s < acc_q) begin
                    fold_d = sym_ext_s;
                end else begin
                    fold_d = acc_q;
                end
            end
            MODE_POP: fold_d = acc_q + sym_pop_s;
            default:  fold_d = acc_q;
        endcase
    end

    // Frame FSM: collect, then shift the result out; outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            count_q     <= '0;
            acc_q       <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid_q <= 1'b0;
                    result_q    <= 1'b0;
                    if (in_valid) begin
                        state_q <= ST_COLLECT;
                        mode_q  <= mode;
                        count_q <= CNT_W'(1);
                        acc_q   <= first_d;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        // Symbols past MAX_LEN are dropped; the frame still ends on in_valid low.
                        if (count_q < MAX_CNT) begin
                            acc_q   <= fold_d;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end else begin
                        state_q     <= ST_OUT;
                        shift_q     <= acc_q;
                        bit_q       <= '0;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_q[0];
                    end
                end
                ST_OUT: begin
                    if (bit_q == LAST_BIT) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        result_q    <= 1'b0;
                        shift_q     <= '0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        bit_q       <= '0;
                    end else begin
                        // result already shows shift_q[0]; present the next bit.
                        shift_q  <= shift_q >> 1;
                        result_q <= shift_q[1];
                        bit_q    <= bit_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    result_q    <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_stream_reduce_serial.sv
// Bench for stream_reduce_serial: directed frames plus random frames against a
// behavioural reduction model.
module tb_stream_reduce_serial;

    localparam int DATA_W  = 4;
    localparam int MAX_LEN = 16;
    localparam int RES_W   = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data;
    logic              out_valid;
    logic              result;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [DATA_W-1:0] sym_a [0:31];

    stream_reduce_serial #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .data      (data),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reduction straight from the mode definitions over the first MAX_LEN symbols.
    function automatic int ref_reduce(input logic [1:0] m, input int len);
        int n;
        int acc;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        acc = (m == 2'b10) ? ((1 << DATA_W) - 1) : 0;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00: acc = acc + int'(sym_a[i]);
                2'b01: if (int'(sym_a[i]) > acc) acc = int'(sym_a[i]);
                2'b10: if (int'(sym_a[i]) < acc) acc = int'(sym_a[i]);
                default: acc = acc + $countones(sym_a[i]);
            endcase
        end
        return acc;
    endfunction

    task automatic drive_symbols(input string tag, input logic [1:0] m, input int len,
                                 output logic timing_ok);
        timing_ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0) check_val({tag, "_idle"}, 32'({out_valid, result}), 32'd0);
            else if (out_valid) timing_ok = 1'b0;
            in_valid = 1'b1;
            mode     = (i == 0) ? m : 2'($urandom);
            data     = sym_a[i];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        data     = DATA_W'($urandom);
        if (out_valid) timing_ok = 1'b0;
        @(negedge clk);
        if (out_valid) timing_ok = 1'b0;
    endtask

    // exp_ov < 0 selects the model; pulse_at >= 0 injects an illegal in_valid during OUT.
    task automatic run_frame(input string tag, input logic [1:0] m, input int len,
                             input int exp_ov, input int pulse_at);
        logic [RES_W-1:0] got;
        int               exp;
        logic             timing_ok;
        exp = (exp_ov >= 0) ? exp_ov : ref_reduce(m, len);
        got = '0;
        drive_symbols(tag, m, len, timing_ok);
        for (int b = 0; b < RES_W; b++) begin
            @(negedge clk);
            if (!out_valid) timing_ok = 1'b0;
            got[b] = result;
            if (b == pulse_at) begin
                in_valid = 1'b1;
                data     = DATA_W'($urandom);
                mode     = 2'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val({tag, "_res"}, 32'(got), 32'(exp));
        check_val({tag, "_tim"}, 32'(timing_ok), 32'd1);
    endtask

    initial begin
        logic tok;
        int   len;
        logic [1:0] m;
        rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; data = '0;
        #23;
        check_val("reset", 32'({out_valid, result}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        sym_a[0] = 4'd3; sym_a[1] = 4'd5; sym_a[2] = 4'd7;
        run_frame("sum357", 2'b00, 3, 15, -1);
        sym_a[0] = 4'd2; sym_a[1] = 4'd9; sym_a[2] = 4'd4;
        run_frame("max294", 2'b01, 3, 9, -1);
        sym_a[0] = 4'hF;
        run_frame("min_single", 2'b10, 1, 15, -1);
        sym_a[0] = 4'd9; sym_a[1] = 4'd3; sym_a[2] = 4'hC;
        run_frame("min93c", 2'b10, 3, 3, -1);
        sym_a[0] = 4'hF; sym_a[1] = 4'hF; sym_a[2] = 4'hF;
        run_frame("pop_fff", 2'b11, 3, 12, -1);
        for (int i = 0; i < 20; i++) sym_a[i] = 4'd1;
        run_frame("sum_ovf", 2'b00, 20, 16, -1);

        // Reset during the third out_valid cycle of a 15-valued frame (bit2 = 1).
        sym_a[0] = 4'd3; sym_a[1] = 4'd5; sym_a[2] = 4'd7;
        drive_symbols("rst_out", 2'b00, 3, tok);
        repeat (3) @(negedge clk);
        check_val("rst_pre", 32'({out_valid, result}), 32'd3);
        rst_n = 1'b0;
        #1;
        check_val("rst_async", 32'({out_valid, result}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sym_a[0] = 4'd1; sym_a[1] = 4'd1;
        run_frame("after_rst", 2'b00, 2, 2, -1);

        // Reset mid-collect discards the partial frame.
        sym_a[0] = 4'hF; sym_a[1] = 4'hF; sym_a[2] = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1; in_valid = 1'b1; mode = 2'b00; data = sym_a[i];
        end
        @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        sym_a[0] = 4'd6;
        run_frame("rst_coll", 2'b01, 1, 6, -1);

        sym_a[0] = 4'd8; sym_a[1] = 4'd8;
        run_frame("b2b_a", 2'b00, 2, 16, -1);
        sym_a[0] = 4'd1;
        run_frame("b2b_b", 2'b00, 1, 1, -1);

        sym_a[0] = 4'd3; sym_a[1] = 4'd5; sym_a[2] = 4'd7;
        run_frame("pulse_out", 2'b00, 3, 15, 2);

        for (int f = 0; f < 1000; f++) begin
            len = int'($urandom_range(20, 1));
            m   = 2'($urandom);
            for (int i = 0; i < len; i++) sym_a[i] = DATA_W'($urandom);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            run_frame("rand", m, len, -1,
                      ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 0)) : -1);
        end

        @(posedge clk); #1;
        check_val("final_idle", 32'({out_valid, result}), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
